// File: rtl/clkdiv_sched.sv
// -----------------------------------------------------------------------------
// clkdiv_sched
// Runtime-programmable multi-channel clock-enable scheduler. Each channel
// divides the ckena-qualified clock by 2*H and produces a 50% square wave plus
// a one-cycle tick on every rising edge. A new half-period is written over a
// valid/ready port and takes effect only at a half-period boundary, so the
// outputs never glitch.
//
// Optional feature macro: CLKDIV_SCHED_ALIGN_EN
//    When defined, adds input 'align', which restarts every running channel
//    from the low phase on the next cycle. This lets channels with equal H be
//    phase-aligned.
//
// Ports
//    clock      in   system clock
//    reset      in   synchronous, active-high reset
//    ckena      in   global count enable; counters hold while low
//    cfg_valid  in   configuration request
//    cfg_ready  out  slot for cfg_chan is free (combinational on cfg_chan)
//    cfg_chan   in   target channel; out-of-range writes are dropped
//    cfg_half   in   half-period in ckena cycles; 0 disables the channel
//    align      in   (CLKDIV_SCHED_ALIGN_EN only) restart all running channels
//    ckout      out  per-channel square wave (registered)
//    tick       out  per-channel rising-edge pulse (registered)
// -----------------------------------------------------------------------------
module clkdiv_sched #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 24,
   localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ckena,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CHAN_W-1:0]   cfg_chan,
   input  logic [WIDTH-1:0]    cfg_half,
`ifdef CLKDIV_SCHED_ALIGN_EN
   input  logic                align,
`endif
   output logic [CHANNELS-1:0] ckout,
   output logic [CHANNELS-1:0] tick
);

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]    half_q [CHANNELS];
   logic [WIDTH-1:0]    half_d [CHANNELS];
   logic [WIDTH-1:0]    cnt_q  [CHANNELS];
   logic [WIDTH-1:0]    cnt_d  [CHANNELS];
   logic [WIDTH-1:0]    pval_q [CHANNELS];
   logic [WIDTH-1:0]    pval_d [CHANNELS];
   logic [CHANNELS-1:0] pend_v_q, pend_v_d;
   logic [CHANNELS-1:0] ckout_q, ckout_d;
   logic [CHANNELS-1:0] tick_q, tick_d;
   logic [CHANNELS-1:0] wr_s;
   logic                chan_ok_s;
   logic                pend_sel_s;
   logic                align_s;

`ifdef CLKDIV_SCHED_ALIGN_EN
   assign align_s = align;
`else
   assign align_s = 1'b0;
`endif

   // Decode the addressed channel, form cfg_ready and the per-channel write strobes.
   always_comb begin
      chan_ok_s  = 1'b0;
      pend_sel_s = 1'b0;
      wr_s       = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         chan_ok_s  = chan_ok_s  | (cfg_chan == CHAN_W'(i));
         pend_sel_s = pend_sel_s | ((cfg_chan == CHAN_W'(i)) & pend_v_q[i]);
      end
      // Out-of-range channels always look ready so the request is consumed and dropped.
      cfg_ready = !reset && (!chan_ok_s || !pend_sel_s);
      for (int i = 0; i < CHANNELS; i++) begin
         wr_s[i] = cfg_valid & cfg_ready & (cfg_chan == CHAN_W'(i));
      end
   end

   // Per-channel next-state: load, count, boundary update and tick generation.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         half_d[i]   = half_q[i];
         cnt_d[i]    = cnt_q[i];
         pval_d[i]   = pval_q[i];
         pend_v_d[i] = pend_v_q[i];
         ckout_d[i]  = ckout_q[i];
         if (half_q[i] == ZERO_W) begin
            // Disabled: a write starts the channel straight away, independent of ckena.
            ckout_d[i] = 1'b0;
            if (wr_s[i]) begin
               if (cfg_half != ZERO_W) begin
                  half_d[i] = cfg_half;
                  cnt_d[i]  = cfg_half - ONE_W;
               end else begin
                  cnt_d[i] = ZERO_W;
               end
            end else if (pend_v_q[i]) begin
               pend_v_d[i] = 1'b0;
               if (pval_q[i] != ZERO_W) begin
                  half_d[i] = pval_q[i];
                  cnt_d[i]  = pval_q[i] - ONE_W;
               end else begin
                  cnt_d[i] = ZERO_W;
               end
            end else begin
               cnt_d[i] = ZERO_W;
            end
         end else begin
            if (align_s) begin
               // Restart from the low phase; pending value stays for a later boundary.
               cnt_d[i]   = half_q[i] - ONE_W;
               ckout_d[i] = 1'b0;
            end else if (ckena && (cnt_q[i] == ZERO_W)) begin
               if (pend_v_q[i]) begin
                  pend_v_d[i] = 1'b0;
                  if (pval_q[i] != ZERO_W) begin
                     half_d[i]  = pval_q[i];
                     cnt_d[i]   = pval_q[i] - ONE_W;
                     ckout_d[i] = ~ckout_q[i];
                  end else begin
                     half_d[i]  = ZERO_W;
                     cnt_d[i]   = ZERO_W;
                     ckout_d[i] = 1'b0;
                  end
               end else begin
                  cnt_d[i]   = half_q[i] - ONE_W;
                  ckout_d[i] = ~ckout_q[i];
               end
            end else if (ckena) begin
               cnt_d[i] = cnt_q[i] - ONE_W;
            end else begin
               cnt_d[i] = cnt_q[i];
            end
            // A write in a boundary cycle only lands in the pending slot, so it
            // waits for the following boundary.
            if (wr_s[i]) begin
               pend_v_d[i] = 1'b1;
               pval_d[i]   = cfg_half;
            end else begin
               pval_d[i] = pval_q[i];
            end
         end
         tick_d[i] = ckout_d[i] & ~ckout_q[i];
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            half_q[i] <= ZERO_W;
            cnt_q[i]  <= ZERO_W;
            pval_q[i] <= ZERO_W;
         end
         pend_v_q <= {CHANNELS{1'b0}};
         ckout_q  <= {CHANNELS{1'b0}};
         tick_q   <= {CHANNELS{1'b0}};
      end else begin
         half_q   <= half_d;
         cnt_q    <= cnt_d;
         pval_q   <= pval_d;
         pend_v_q <= pend_v_d;
         ckout_q  <= ckout_d;
         tick_q   <= tick_d;
      end
   end

   assign ckout = ckout_q;
   assign tick  = tick_q;

endmodule

// File: tb/tb_clkdiv_sched.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_sched
// Scoreboard bench for clkdiv_sched (4 channels, 24-bit half-period). A
// phase-based reference model predicts ckout/tick for the next cycle and pushes
// the prediction into a queue. A monitor pops and compares on every falling
// edge. cfg_ready is checked against the model each cycle. Define
// CLKDIV_SCHED_ALIGN_EN to also exercise the align port.
// -----------------------------------------------------------------------------
module tb_clkdiv_sched;
   localparam int C = 4;
   localparam int W = 24;

   logic          clock = 1'b0;
   logic          reset, ckena, cfg_valid, align;
   logic [1:0]    cfg_chan;
   logic [W-1:0]  cfg_half;
   logic          cfg_ready;
   logic [C-1:0]  ckout, tick;

   always #5 clock = ~clock;

   clkdiv_sched #(.CHANNELS(C), .WIDTH(W)) dut (
      .clock(clock), .reset(reset), .ckena(ckena), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_half(cfg_half),
`ifdef CLKDIV_SCHED_ALIGN_EN
      .align(align),
`endif
      .ckout(ckout), .tick(tick)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct { logic [C-1:0] ck; logic [C-1:0] tk; int at; } exp_t;
   exp_t sbq[$];

   // Reference model: channel phase p in [0, 2H); ckout is high in the upper half.
   int mh[C], mp[C], mpval[C];
   bit mpv[C];

   function automatic bit m_ck(int i);
      return (mh[i] > 0) && (mp[i] >= mh[i]);
   endfunction

   task automatic model_step();
      bit rdy, acc, old_ck, new_ck;
      int ch, hv, np;
      exp_t e;
      ch  = int'(cfg_chan);
      hv  = int'(cfg_half);
      rdy = !reset && ((ch >= C) || !mpv[ch]);
      n_cmp++;
      if (cfg_ready !== rdy) begin
         n_err++;
         $display("FAIL cfg_ready cyc=%0d chan=%0d got=%b exp=%b", cyc, ch, cfg_ready, rdy);
      end
      acc  = cfg_valid && rdy && (ch < C);
      e.ck = '0;
      e.tk = '0;
      e.at = cyc + 1;
      for (int i = 0; i < C; i++) begin
         if (reset) begin
            mh[i] = 0; mp[i] = 0; mpv[i] = 1'b0; mpval[i] = 0;
         end else begin
            old_ck = m_ck(i);
            if (mh[i] == 0) begin
               if (acc && ch == i && hv != 0) begin
                  mh[i] = hv; mp[i] = 0;
               end else if (mpv[i]) begin
                  if (mpval[i] != 0) begin mh[i] = mpval[i]; mp[i] = 0; end
                  mpv[i] = 1'b0;
               end
            end else begin
               if (align) begin
                  mp[i] = 0;
               end else if (ckena) begin
                  np = mp[i] + 1;
                  if (np == mh[i] || np == 2 * mh[i]) begin
                     new_ck = (np == mh[i]);
                     if (mpv[i]) begin
                        if (mpval[i] == 0) begin mh[i] = 0; mp[i] = 0; end
                        else begin mh[i] = mpval[i]; mp[i] = new_ck ? mh[i] : 0; end
                        mpv[i] = 1'b0;
                     end else begin
                        mp[i] = np % (2 * mh[i]);
                     end
                  end else begin
                     mp[i] = np;
                  end
               end
               if (acc && ch == i) begin mpv[i] = 1'b1; mpval[i] = hv; end
            end
            e.ck[i] = m_ck(i);
            e.tk[i] = m_ck(i) & ~old_ck;
         end
      end
      sbq.push_back(e);
   endtask

   // Model runs just after the falling edge, with inputs stable for the next rising edge.
   initial begin
      for (int i = 0; i < C; i++) begin mh[i] = 0; mp[i] = 0; mpv[i] = 1'b0; mpval[i] = 0; end
      forever begin
         @(negedge clock);
         #1;
         model_step();
      end
   end

   // Monitor: on each falling edge, compare DUT outputs with the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         cyc++;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (ckout !== e.ck || tick !== e.tk) begin
               n_err++;
               $display("FAIL outputs cyc=%0d ckout got=%b exp=%b tick got=%b exp=%b",
                        cyc, ckout, e.ck, tick, e.tk);
            end
         end
      end
   end

   task automatic idle(int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   // Hold a write until the DUT accepts it; treat an expired wait as a failure.
   task automatic do_write(int ch, int h);
      bit got;
      got       = 1'b0;
      cfg_valid = 1'b1;
      cfg_chan  = 2'(ch);
      cfg_half  = W'(h);
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clock);
         got = cfg_ready;
         @(posedge clock);
         #1;
      end
      cfg_valid = 1'b0;
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL write_accept ch=%0d got=0 exp=1", ch);
      end
   endtask

   task automatic wait_ck_high(int ch);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clock);
         seen = ckout[ch];
         @(posedge clock);
         #1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL ck_high_wait ch=%0d got=0 exp=1", ch);
      end
   endtask

   initial begin
      reset = 1'b1; ckena = 1'b0; cfg_valid = 1'b0; align = 1'b0;
      cfg_chan = 2'd0; cfg_half = {W{1'b0}};
      idle(3);
      reset = 1'b0;
      ckena = 1'b1;
      idle(100);

      // Basic rate, rate change with a stalled second write, disable while high.
      do_write(0, 3);
      idle(30);
      do_write(1, 5);
      idle(7);
      do_write(1, 2);
      do_write(1, 4);
      idle(20);
      do_write(2, 4);
      wait_ck_high(2);
      do_write(2, 0);
      idle(20);

      // ckena gating on ch0, then reset with a write still pending.
      for (int k = 0; k < 40; k++) begin
         ckena = (k % 3) != 1;
         idle(1);
      end
      ckena = 1'b1;
      do_write(0, 5);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(10);

`ifdef CLKDIV_SCHED_ALIGN_EN
      do_write(0, 4);
      idle(3);
      do_write(3, 4);
      idle(5);
      align = 1'b1;
      idle(1);
      align = 1'b0;
      idle(15);
`endif

      // Randomized traffic on all channels.
      for (int k = 0; k < 3000; k++) begin
         ckena     = ($urandom_range(0, 3) != 0);
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_chan  = 2'($urandom_range(0, C - 1));
         cfg_half  = ($urandom_range(0, 7) == 0) ? {W{1'b0}} : W'($urandom_range(1, 6));
         reset     = ($urandom_range(0, 499) == 0);
`ifdef CLKDIV_SCHED_ALIGN_EN
         align     = ($urandom_range(0, 99) == 0);
`endif
         idle(1);
      end
      reset = 1'b0; cfg_valid = 1'b0; align = 1'b0; ckena = 1'b1;
      idle(5);
      @(negedge clock);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clkdiv_sched.md
# clkdiv_sched

Runtime-programmable multi-channel clock-enable scheduler. It owns a bank of divider channels that produce square-wave outputs and rising-edge tick pulses, like fixed dividers feeding tx/rx/led paths. Unlike those, each channel's rate is written at run time over a valid/ready port. A new rate is applied only at a half-period boundary, so outputs never glitch. It sits between the debounced reset/control logic and the serial and indicator paths that need rate-switchable timing.

## Interface
- Channels, 4, number of divider channels (1..16)
- Width, 24, half-period counter width in bits
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ckena  in  1  global count enable; counters hold while low
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration slot for cfg_chan is free
- cfg_chan  in  $clog2(Channels) (min 1)  target channel
- cfg_half  in  Width  half-period in clock cycles; 0 = disable channel
- ckout  out  Channels  per-channel square wave
- tick  out  Channels  one-cycle pulse coincident with each ckout rising edge

## Operation
- Per-channel state:
  - active half-period H (Width bits)
  - down-counter cnt
  - ckout register
  - pending value plus pending-valid bit
- cfg_ready = !reset && !pend_v[cfg_chan]. It is combinational on cfg_chan.
- If cfg_chan >= Channels: cfg_ready = 1 and the write is dropped.
- A write is accepted on cfg_valid && cfg_ready. The pending slot is loaded the next cycle.
- Only one write is outstanding per channel. Later writes stall until the pending value is consumed.
- Channel states:
  - DISABLED (H = 0): ckout = 0, cnt idle.
  - RUNNING (H > 0): ckout toggles every H ckena-high cycles.
- DISABLED with a pending nonzero value: the next cycle loads H, sets cnt = H-1, keeps ckout = 0, clears pending, and enters RUNNING. This happens regardless of ckena.
- DISABLED with a pending zero: the pending bit is cleared next cycle. There is no other effect.
- RUNNING, boundary = cycle with ckena = 1 and cnt = 0. At a boundary:
  - Pending nonzero P: H = P, cnt = P-1, ckout toggles, pending cleared.
  - Pending zero: ckout forced to 0, H = 0, pending cleared, enter DISABLED.
  - No pending value: cnt = H-1, ckout toggles.
- RUNNING, non-boundary with ckena = 1: cnt decrements.
- ckena = 0: cnt and ckout hold. A pending value waits for the next boundary.
- tick[i] = 1 in exactly the cycles where ckout[i] goes 0 -> 1.
- Channels are independent. Writes and boundaries on different channels never interact.
- Arithmetic: cnt is a Width-bit unsigned counter. H = 1 gives a toggle every ckena cycle (period 2). H = 2^Width-1 is the maximum.

## Timing
- Reset values: ckout = 0, tick = 0, all H = 0, all pending cleared, cfg_ready = 0 while reset is high. In the cycle after reset releases, cfg_ready = 1.
- Reset mid-operation: all outputs drop to 0 in the cycle after reset is sampled. Pending writes are discarded.
- Enable latency:
  - write accepted at cycle t -> RUNNING at t+1 -> first ckout rise after H ckena-high cycles.
  - With ckena held high, that first rise is at t+1+H.
- Period = 2H ckena-high cycles, 50% duty.
- A write accepted in the same cycle as a boundary misses that boundary. It applies at the following boundary.
- cfg_ready for a channel returns high the cycle after its pending value is consumed.
- ckout and tick are registered outputs with no combinational paths from inputs. cfg_ready is the only combinational output.

## Configuration
- CLKDIV_SCHED_ALIGN_EN defined:
  - Adds input port `align` (1 bit).
  - A cycle with align = 1 (not in reset) restarts every RUNNING channel on the next cycle: cnt = H-1, ckout = 0, tick = 0.
  - Pending values are kept.
  - All channels with equal H are thereby phase-aligned.
  - align takes priority over a boundary in the same cycle.
- Undefined: no align port. Channel phases depend only on enable/write history.

## Test plan
- Reset release, no writes -> ckout = 4'b0000, tick = 0, cfg_ready = 1 for 100 cycles.
- Write ch0 H = 3, ckena = 1 -> ckout[0] first rises 4 cycles after acceptance, then period 6. tick[0] pulses once per period, coincident with each rise.
- ch1 running H = 5; write H = 2 mid-half-period -> no change until the next boundary, then half-periods of 2. A second write issued before that boundary sees cfg_ready = 0 until the boundary cycle + 1.
- ch2 running H = 4; write 0 while ckout[2] = 1 -> ckout[2] falls at the next boundary and stays 0, tick never fires again.
- ckena toggled 1-0-1 on ch0 with H = 3 -> ckout holds during the low cycles and period = 6 counted in ckena-high cycles. Assert reset mid-period -> all outputs 0 in the next cycle and the pending write is lost.
- With CLKDIV_SCHED_ALIGN_EN: ch0 and ch3 both H = 4 with different phases; pulse align -> both ckout low the next cycle and rise together 4 cycles later.
